// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C state encoding, byte size and ACK/NACK line levels
package i2c_pkg;

   localparam int BITS_PER_BYTE = 8;

   // SDA line levels seen by the master during the acknowledge bit
   localparam logic ACK_LEVEL  = 1'b0;
   localparam logic NACK_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_DATA,
      ST_DATA_ACK,
      ST_IGNORE
   } i2c_state_t;

   // Open-drain: the only way to put a level on SDA is to pull it low
   function automatic logic drive_for(input logic level);
      return ~level;
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - synchroniser, optional majority filter (I2C_RX_GLITCH_FILTER_EN) and edge detect
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_line,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   w_sync;
   logic                   w_level;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
      end
   end

   assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef I2C_RX_GLITCH_FILTER_EN
   logic [2:0] r_flt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flt <= '1;
      end else begin
         r_flt <= {r_flt[1:0], w_sync};
      end
   end

   // A single-cycle pulse only ever occupies one of the three taps
   assign w_level = (r_flt[0] & r_flt[1]) | (r_flt[0] & r_flt[2]) | (r_flt[1] & r_flt[2]);
`else
   assign w_level = w_sync;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev <= 1'b1;
      end else begin
         r_prev <= w_level;
      end
   end

   assign o_level = w_level;
   assign o_rise  = w_level & ~r_prev;
   assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/i2c_receiver.sv
// rtl/i2c_receiver.sv - write-only I2C target receiver; glitch filter via I2C_RX_GLITCH_FILTER_EN
module i2c_receiver
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = 7'h50,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_overrun,
   output logic       bus_start,
   output logic       bus_stop,
   output logic       busy
);

   localparam logic [3:0] CNT_FULL = 4'(BITS_PER_BYTE);
   localparam logic [3:0] CNT_LAST = 4'(BITS_PER_BYTE - 1);

   logic w_scl, w_scl_rise, w_scl_fall;
   logic w_sda, w_sda_rise, w_sda_fall;
   logic w_start, w_stop;

   i2c_state_t r_state, w_state_n;
   logic [3:0] r_bit_cnt, w_bit_cnt_n;
   logic [7:0] r_shift, w_shift_n;
   logic [7:0] r_rx_data, w_rx_data_n;
   logic [7:0] w_byte;
   logic       r_sda_oe, w_sda_oe_n;
   logic       r_ack_on, w_ack_on_n;
   logic       r_busy, w_busy_n;
   logic       r_rx_valid, w_rx_valid_n;
   logic       r_rx_overrun, w_rx_overrun_n;
   logic       r_bus_start, w_bus_start_n;
   logic       r_bus_stop, w_bus_stop_n;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_line  (scl_in),
      .o_level (w_scl),
      .o_rise  (w_scl_rise),
      .o_fall  (w_scl_fall)
   );

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_line  (sda_in),
      .o_level (w_sda),
      .o_rise  (w_sda_rise),
      .o_fall  (w_sda_fall)
   );

   assign w_start = w_sda_fall & w_scl;
   assign w_stop  = w_sda_rise & w_scl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_rx_data    <= '0;
         r_sda_oe     <= 1'b0;
         r_ack_on     <= 1'b0;
         r_busy       <= 1'b0;
         r_rx_valid   <= 1'b0;
         r_rx_overrun <= 1'b0;
         r_bus_start  <= 1'b0;
         r_bus_stop   <= 1'b0;
      end else begin
         r_state      <= w_state_n;
         r_bit_cnt    <= w_bit_cnt_n;
         r_shift      <= w_shift_n;
         r_rx_data    <= w_rx_data_n;
         r_sda_oe     <= w_sda_oe_n;
         r_ack_on     <= w_ack_on_n;
         r_busy       <= w_busy_n;
         r_rx_valid   <= w_rx_valid_n;
         r_rx_overrun <= w_rx_overrun_n;
         r_bus_start  <= w_bus_start_n;
         r_bus_stop   <= w_bus_stop_n;
      end
   end

   always_comb begin
      w_state_n      = r_state;
      w_bit_cnt_n    = r_bit_cnt;
      w_shift_n      = r_shift;
      w_rx_data_n    = r_rx_data;
      w_sda_oe_n     = r_sda_oe;
      w_ack_on_n     = r_ack_on;
      w_busy_n       = r_busy;
      w_rx_valid_n   = 1'b0;
      w_rx_overrun_n = 1'b0;
      w_bus_start_n  = 1'b0;
      w_bus_stop_n   = 1'b0;
      w_byte         = {r_shift[6:0], w_sda};

      if (w_stop) begin
         w_bus_stop_n = 1'b1;
         w_state_n    = ST_IDLE;
         w_bit_cnt_n  = '0;
         w_sda_oe_n   = drive_for(NACK_LEVEL);
         w_ack_on_n   = 1'b0;
         w_busy_n     = 1'b0;
      end else if (w_start) begin
         w_bus_start_n = 1'b1;
         w_state_n     = ST_ADDR;
         w_bit_cnt_n   = '0;
         w_sda_oe_n    = drive_for(NACK_LEVEL);
         w_ack_on_n    = 1'b0;
      end else begin
         if (w_scl_rise) begin
            w_bit_cnt_n = (r_bit_cnt == CNT_FULL) ? CNT_FULL : r_bit_cnt + 4'd1;
            w_shift_n   = w_byte;
         end
         case (r_state)
            ST_ADDR: begin
               if (w_scl_rise && r_bit_cnt == CNT_LAST) begin
                  // Reads are not supported, so R/W=1 is handled like a foreign address
                  if (w_byte[7:1] == DEV_ADDR && w_byte[0] == 1'b0) begin
                     w_state_n = ST_ADDR_ACK;
                     w_busy_n  = 1'b1;
                  end else begin
                     w_state_n = ST_IGNORE;
                     w_busy_n  = 1'b0;
                  end
               end
            end
            ST_ADDR_ACK, ST_DATA_ACK: begin
               if (w_scl_fall) begin
                  if (!r_ack_on) begin
                     w_sda_oe_n = drive_for(ACK_LEVEL);
                     w_ack_on_n = 1'b1;
                  end else begin
                     w_sda_oe_n  = drive_for(NACK_LEVEL);
                     w_ack_on_n  = 1'b0;
                     w_state_n   = ST_DATA;
                     w_bit_cnt_n = '0;
                  end
               end
            end
            ST_DATA: begin
               if (w_scl_rise && r_bit_cnt == CNT_LAST) begin
                  if (rx_ready) begin
                     w_rx_data_n  = w_byte;
                     w_rx_valid_n = 1'b1;
                     w_state_n    = ST_DATA_ACK;
                  end else begin
                     w_rx_overrun_n = 1'b1;
                     w_state_n      = ST_IGNORE;
                     w_busy_n       = 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign sda_oe     = r_sda_oe;
   assign rx_data    = r_rx_data;
   assign rx_valid   = r_rx_valid;
   assign rx_overrun = r_rx_overrun;
   assign bus_start  = r_bus_start;
   assign bus_stop   = r_bus_stop;
   assign busy       = r_busy;

endmodule

// File: tb/tb_i2c_receiver.sv
// tb/tb_i2c_receiver.sv - directed self-checking bench for i2c_receiver
module tb_i2c_receiver;
   import i2c_pkg::*;

   localparam int Q = 8;
`ifdef I2C_RX_GLITCH_FILTER_EN
   localparam int EXP_LAT = 5;
`else
   localparam int EXP_LAT = 3;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       rx_ready = 1'b1;
   logic       sda_line;
   logic       sda_oe;
   logic [7:0] rx_data;
   logic       rx_valid, rx_overrun, bus_start, bus_stop, busy;

   int n_assert = 0;
   int n_fail = 0;
   int cyc = 0;
   int n_valid = 0, n_ovr = 0, n_start = 0, n_stop = 0, n_oe = 0;
   int valid_cyc = 0, rise_cyc = 0;
   logic [7:0] last_data = 8'h00;

   int s_valid, s_ovr, s_start, s_stop, s_oe;
   logic ack;

   assign sda_line = m_sda & ~sda_oe;

   i2c_receiver dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .scl_in     (scl),
      .sda_in     (sda_line),
      .sda_oe     (sda_oe),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .rx_overrun (rx_overrun),
      .bus_start  (bus_start),
      .bus_stop   (bus_stop),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_valid) begin
         n_valid   = n_valid + 1;
         last_data = rx_data;
         valid_cyc = cyc;
      end
      if (rx_overrun) n_ovr = n_ovr + 1;
      if (bus_start) n_start = n_start + 1;
      if (bus_stop) n_stop = n_stop + 1;
      if (sda_oe) n_oe = n_oe + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic snap();
      s_valid = n_valid;
      s_ovr   = n_ovr;
      s_start = n_start;
      s_stop  = n_stop;
      s_oe    = n_oe;
   endtask

   task automatic send_bit(input logic b);
      m_sda = b;
      tick(Q);
      scl = 1'b1;
      rise_cyc = cyc;
      tick(Q);
      scl = 1'b0;
      tick(Q);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) send_bit(b[7-i]);
   endtask

   task automatic ack_bit(output logic a);
      m_sda = 1'b1;
      tick(Q);
      scl = 1'b1;
      tick(Q / 2);
      a = sda_line;
      tick(Q / 2);
      scl = 1'b0;
      tick(Q);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic a);
      send_bits(b, 8);
      ack_bit(a);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1;
      tick(Q);
      scl = 1'b1;
      tick(Q);
      m_sda = 1'b0;
      tick(Q);
      scl = 1'b0;
      tick(Q);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0;
      tick(Q);
      scl = 1'b1;
      tick(Q);
      m_sda = 1'b1;
      tick(Q);
   endtask

   initial begin
      // Reset state
      tick(3);
      check("rst_sda_oe", sda_oe, 1'b0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_rx_valid", rx_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_strobes", {bus_start, bus_stop, rx_overrun}, 3'b000);
      rst_n = 1'b1;
      tick(4);

      // Good write: 0x50+W, 0x9D
      snap();
      i2c_start();
      send_byte(8'hA0, ack);
      check("w_addr_ack", ack, ACK_LEVEL);
      check("w_busy", busy, 1'b1);
      send_byte(8'h9D, ack);
      check("w_data_ack", ack, ACK_LEVEL);
      check("w_latency", valid_cyc - rise_cyc, EXP_LAT);
      i2c_stop();
      tick(4);
      check("w_valid_cnt", n_valid - s_valid, 1);
      check("w_last_data", last_data, 8'h9D);
      check("w_rx_data", rx_data, 8'h9D);
      check("w_start_cnt", n_start - s_start, 1);
      check("w_stop_cnt", n_stop - s_stop, 1);
      check("w_busy_end", busy, 1'b0);
      check("w_state_idle", dut.r_state, ST_IDLE);

      // Foreign address 0x51+W, then a data byte that must be ignored
      snap();
      i2c_start();
      send_byte(8'hA2, ack);
      check("na_ack", ack, NACK_LEVEL);
      check("na_busy", busy, 1'b0);
      send_byte(8'h12, ack);
      check("na_cnt_sat", dut.r_bit_cnt, 4'd8);
      check("na_state", dut.r_state, ST_IGNORE);
      i2c_stop();
      tick(4);
      check("na_oe_cycles", n_oe - s_oe, 0);
      check("na_valid_cnt", n_valid - s_valid, 0);

      // Read request 0x50+R
      i2c_start();
      send_byte(8'hA1, ack);
      check("rd_ack", ack, NACK_LEVEL);
      check("rd_state", dut.r_state, ST_IGNORE);
      i2c_stop();
      tick(4);
      check("rd_state_idle", dut.r_state, ST_IDLE);

      // Overrun: 0x3C with sink not ready
      snap();
      i2c_start();
      send_byte(8'hA0, ack);
      check("ov_addr_ack", ack, ACK_LEVEL);
      rx_ready = 1'b0;
      send_byte(8'h3C, ack);
      check("ov_ack", ack, NACK_LEVEL);
      check("ov_state", dut.r_state, ST_IGNORE);
      i2c_stop();
      rx_ready = 1'b1;
      tick(4);
      check("ov_cnt", n_ovr - s_ovr, 1);
      check("ov_valid_cnt", n_valid - s_valid, 0);
      check("ov_rx_data", rx_data, 8'h9D);

      // Repeated START after a partial byte
      snap();
      i2c_start();
      send_byte(8'hA0, ack);
      send_bits(8'hF0, 4);
      i2c_start();
      check("rs_state", dut.r_state, ST_ADDR);
      send_byte(8'hA0, ack);
      check("rs_addr_ack", ack, ACK_LEVEL);
      send_byte(8'hA5, ack);
      check("rs_data_ack", ack, ACK_LEVEL);
      i2c_stop();
      tick(4);
      check("rs_valid_cnt", n_valid - s_valid, 1);
      check("rs_last_data", last_data, 8'hA5);
      check("rs_start_cnt", n_start - s_start, 2);

      // Reset while driving the address ACK
      i2c_start();
      send_bits(8'hA0, 8);
      check("ra_state", dut.r_state, ST_ADDR_ACK);
      check("ra_oe_before", sda_oe, 1'b1);
      snap();
      rst_n = 1'b0;
      #1;
      check("ra_oe_async", sda_oe, 1'b0);
      check("ra_busy", busy, 1'b0);
      scl = 1'b1;
      m_sda = 1'b1;
      tick(4);
      rst_n = 1'b1;
      tick(4);
      check("ra_no_strobe", (n_start - s_start) + (n_stop - s_stop) + (n_valid - s_valid), 0);

      // Normal transfer after the reset
      snap();
      i2c_start();
      send_byte(8'hA0, ack);
      check("pr_addr_ack", ack, ACK_LEVEL);
      send_byte(8'h5A, ack);
      check("pr_data_ack", ack, ACK_LEVEL);
      i2c_stop();
      tick(4);
      check("pr_valid_cnt", n_valid - s_valid, 1);
      check("pr_rx_data", rx_data, 8'h5A);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_receiver.md
I2C_RECEIVER -- requirements
Module: i2c_receiver

Interface
REQ-001 Parameter DEV_ADDR, default 7'h50, is the 7-bit target address this block answers to.
REQ-002 Parameter SYNC_STAGES, default 2, is the synchroniser depth on SCL and SDA (minimum 2).
REQ-003 clk  input  1  system clock; all logic rising-edge; one clock domain only.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 scl_in  input  1  SCL line level, asynchronous to clk.
REQ-006 sda_in  input  1  SDA line level, asynchronous to clk.
REQ-007 sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 rx_data  output  8  last received data byte, MSB first on the wire.
REQ-009 rx_valid  output  1  one-cycle strobe: rx_data holds a new byte.
REQ-010 rx_ready  input  1  sink can accept a byte; sampled at byte completion.
REQ-011 rx_overrun  output  1  one-cycle strobe: byte dropped, rx_ready low.
REQ-012 bus_start / bus_stop  output  1 each  one-cycle strobes on START / STOP detection.
REQ-013 busy  output  1  high from an addressed START until STOP or NACK.

Function
REQ-014 SCL and SDA pass through SYNC_STAGES flops; edges are detected on the synchronised signals only.
REQ-015 START = synchronised SDA 1->0 while SCL high; STOP = SDA 0->1 while SCL high; each pulses its strobe in the detection cycle.
REQ-016 Data bits are sampled on the detected SCL rising edge; SDA changes while SCL high are START/STOP, never data.
REQ-017 FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-018 IDLE -> ADDR on START; bit counter cleared to 0.
REQ-019 ADDR shifts 8 bits; after bit 8: address match and R/W=0 -> ADDR_ACK; otherwise -> IGNORE with sda_oe held 0.
REQ-020 R/W=1 (read) is unsupported; it is treated as no match and goes to IGNORE.
REQ-021 ADDR_ACK/DATA_ACK: sda_oe asserts on the SCL falling edge after bit 8 and releases on the next SCL falling edge; the state then moves to DATA.
REQ-022 DATA: after bit 8, if rx_ready=1: rx_data updates, rx_valid pulses once, ACK is driven.
REQ-023 If rx_ready=0 at byte completion: rx_data is unchanged, rx_overrun pulses, no ACK is driven (NACK), and the state goes to IGNORE.
REQ-024 Repeated START in any state -> ADDR, counter cleared; a partial byte is discarded without a strobe.
REQ-025 STOP in any state -> IDLE, sda_oe=0, busy=0; a partial byte is discarded.
REQ-026 IGNORE leaves only on START or STOP.
REQ-027 The bit counter is 4 bits wide and saturates at 8; it never wraps.
REQ-028 The rx_valid latency is exactly SYNC_STAGES+1 clk after the raw SCL rise of bit 8.

Reset
REQ-029 While rst_n=0: state IDLE, sda_oe=0, rx_data=8'h00, rx_valid=0, rx_overrun=0, bus_start=0, bus_stop=0, busy=0, and synchroniser flops are set to 1 (idle bus).
REQ-030 A reset asserted mid-transfer releases SDA immediately (asynchronously) and emits no strobe.

Configuration
REQ-031 With I2C_RX_GLITCH_FILTER_EN defined, each synchronised line passes a 3-sample majority filter, adding 2 clk latency and suppressing pulses of 1 clk or less.
REQ-032 Without I2C_RX_GLITCH_FILTER_EN, the filter is absent and the latency is as in REQ-028.

Structure
REQ-033 Package i2c_pkg holds the FSM state enum, the BITS_PER_BYTE=8 constant, and ACK/NACK level constants shared with the transmitter.
REQ-034 Sub-module i2c_line_sync performs synchronisation, the optional filter, and rise/fall detection; it is instantiated once per line.

Verification
REQ-035 START, address 0x50+W, data 0x9D, STOP with rx_ready=1 -> two ACKs, rx_valid once with rx_data=0x9D, bus_start and bus_stop pulse once each.
REQ-036 Address 0x51+W -> sda_oe stays 0 throughout, no rx_valid, busy=0.
REQ-037 Address 0x50+R -> NACK, state IGNORE, returns to IDLE on STOP.
REQ-038 Data byte 0x3C sent with rx_ready=0 -> rx_overrun pulses, NACK, rx_data keeps its previous value.
REQ-039 Repeated START after 4 data bits, then 0x50+W and byte 0xA5 -> only 0xA5 is strobed.
REQ-040 rst_n low during ADDR_ACK -> sda_oe 0 within the same cycle; after release, the next full transfer completes normally.
